// File: rtl/matrix_ops_pkg.sv
// Shared types and sizing helpers for the matrix_ops datapath blocks.
package matrix_ops_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mvm_state_e;

  // Counter width for an index range of n values; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Full-precision accumulator width for a COLS-term dot product.
  function automatic int acc_width_default(input int data_width, input int cols);
    return 2 * data_width + $clog2(cols) + 1;
  endfunction

endpackage

// File: rtl/mvm_mac_unit.sv
// Combinational multiply-accumulate: sum_o = extend(a_i * b_i) + acc_i, wrapping.
module mvm_mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int SIGNED     = 0
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [ACC_WIDTH-1:0]  acc_i,
  output logic [ACC_WIDTH-1:0]  sum_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]        prod;
  logic [ACC_WIDTH-1:0] prod_ext;

  // Operands are widened to PW first; the low PW bits of the product of
  // sign-extended operands are the exact two's-complement product.
  generate
    if (SIGNED != 0) begin : g_signed
      assign prod     = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i} *
                        {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};
      assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    end else begin : g_unsigned
      assign prod     = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};
      assign prod_ext = {{(ACC_WIDTH-PW){1'b0}}, prod};
    end
  endgenerate

  assign sum_o = acc_i + prod_ext;

endmodule

// File: rtl/matrix_vector_mac.sv
// Element-serial matrix x vector MAC with start/busy/valid/ack handshake.
//  state   | meaning
//  IDLE    | waiting for i_start; operands captured on acceptance
//  RUN     | one product per cycle, row-major over (row, col)
//  DONE    | o_valid high, o_result held until i_ack
module matrix_vector_mac
  import matrix_ops_pkg::*;
#(
  parameter int ROWS       = 5,
  parameter int COLS       = 5,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = acc_width_default(DATA_WIDTH, COLS),
  parameter int SIGNED     = 0
) (
  input  logic                           clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_accum,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0] i_matrix,
  input  logic [COLS*DATA_WIDTH-1:0]     i_vector,
  input  logic                           i_ack,
  output logic                           o_busy,
  output logic                           o_valid,
  output logic [ROWS*ACC_WIDTH-1:0]      o_result
);

  localparam int ROW_W = clog2_min1(ROWS);
  localparam int COL_W = clog2_min1(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  mvm_state_e state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic load, clear, mac_en;

  logic [DATA_WIDTH-1:0] mat_q [ROWS][COLS];
  logic [DATA_WIDTH-1:0] vec_q [COLS];
  logic [ACC_WIDTH-1:0]  res_q [ROWS];
  logic [ACC_WIDTH-1:0]  mac_sum;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    load    = 1'b0;
    clear   = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          load    = 1'b1;
          clear   = !i_accum;
          row_d   = '0;
          col_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mac_en = 1'b1;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = ST_DONE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      ST_DONE: begin
        // A start arriving with the ack is dropped; it must be reissued in IDLE.
        if (i_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        res_q[r] <= '0;
        for (int c = 0; c < COLS; c++) mat_q[r][c] <= '0;
      end
      for (int c = 0; c < COLS; c++) vec_q[c] <= '0;
    end else begin
      if (load) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            mat_q[r][c] <= i_matrix[(r*COLS+c)*DATA_WIDTH +: DATA_WIDTH];
        for (int c = 0; c < COLS; c++)
          vec_q[c] <= i_vector[c*DATA_WIDTH +: DATA_WIDTH];
      end
      if (clear) begin
        for (int r = 0; r < ROWS; r++) res_q[r] <= '0;
      end
      if (mac_en) res_q[row_q] <= mac_sum;
    end
  end

  mvm_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED)
  ) u_mac (
    .a_i  (mat_q[row_q][col_q]),
    .b_i  (vec_q[col_q]),
    .acc_i(res_q[row_q]),
    .sum_o(mac_sum)
  );

  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_res
      assign o_result[r*ACC_WIDTH +: ACC_WIDTH] = res_q[r];
    end
  endgenerate

  assign o_busy  = (state_q == ST_RUN);
  assign o_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_matrix_vector_mac.sv
// Directed bench for matrix_vector_mac: unsigned and signed 5x5 instances.
module tb_matrix_vector_mac;

  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start, accum, ack, busy, valid;
  logic [199:0] matrix;
  logic [39:0]  vector;
  logic [99:0]  result;

  logic         s_start, s_accum, s_ack, s_busy, s_valid;
  logic [199:0] s_matrix;
  logic [39:0]  s_vector;
  logic [99:0]  s_result;

  int checks   = 0;
  int failures = 0;

  matrix_vector_mac u_dut (
    .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_accum(accum),
    .i_matrix(matrix), .i_vector(vector), .i_ack(ack),
    .o_busy(busy), .o_valid(valid), .o_result(result)
  );

  matrix_vector_mac #(.SIGNED(1)) u_dut_s (
    .clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_accum(s_accum),
    .i_matrix(s_matrix), .i_vector(s_vector), .i_ack(s_ack),
    .o_busy(s_busy), .o_valid(s_valid), .o_result(s_result)
  );

  function automatic logic [199:0] mat_ident();
    logic [199:0] m = '0;
    for (int r = 0; r < 5; r++) m[(r*5+r)*8 +: 8] = 8'd1;
    return m;
  endfunction

  function automatic logic [199:0] mat_fill(input logic [7:0] b);
    logic [199:0] m;
    for (int i = 0; i < 25; i++) m[i*8 +: 8] = b;
    return m;
  endfunction

  function automatic logic [199:0] mat_rpc();
    logic [199:0] m;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) m[(r*5+c)*8 +: 8] = 8'(r + c);
    return m;
  endfunction

  // Latency counts the accepting edge as cycle 1.
  task automatic run_op(input bit sgn, input logic [199:0] m, input logic [39:0] v,
                        input logic acc, output int lat);
    @(negedge clk);
    if (sgn) begin s_matrix = m; s_vector = v; s_accum = acc; s_start = 1'b1; end
    else     begin matrix = m;   vector = v;   accum = acc;   start = 1'b1;   end
    @(posedge clk);
    lat = 1;
    #1;
    start = 1'b0; s_start = 1'b0;
    matrix = '1; vector = '1; s_matrix = '1; s_vector = '1;
    accum = ~acc; s_accum = ~acc;
    while (!(sgn ? s_valid : valid) && lat < 100) begin
      @(posedge clk); lat++; #1;
    end
  endtask

  task automatic do_ack(input bit sgn);
    @(negedge clk);
    if (sgn) s_ack = 1'b1; else ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0; s_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; accum = 0; ack = 0; matrix = '0; vector = '0;
    s_start = 0; s_accum = 0; s_ack = 0; s_matrix = '0; s_vector = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, valid, result} !== '0) begin
      failures++; $display("FAIL reset_u got busy=%b valid=%b result=%h expected all 0", busy, valid, result);
    end
    checks++;
    if ({s_busy, s_valid, s_result} !== '0) begin
      failures++; $display("FAIL reset_s got busy=%b valid=%b result=%h expected all 0", s_busy, s_valid, s_result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, valid} !== 2'b00) begin
      failures++; $display("FAIL reset_idle got busy=%b valid=%b expected 0 0", busy, valid);
    end
  endtask

  task automatic test_identity();
    int lat;
    int exp [5] = '{1, 2, 3, 4, 5};
    run_op(0, mat_ident(), {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, lat);
    checks++;
    if (lat !== 26) begin
      failures++; $display("FAIL identity_latency got %0d expected 26", lat);
    end
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (result[r*AW +: AW] !== AW'(exp[r])) begin
        failures++; $display("FAIL identity_y%0d got %0d expected %0d", r, result[r*AW +: AW], exp[r]);
      end
    end
    do_ack(0);
  endtask

  task automatic test_unsigned_max();
    int lat;
    run_op(0, mat_fill(8'hFF), {5{8'hFF}}, 1'b0, lat);
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (result[r*AW +: AW] !== AW'(325125)) begin
        failures++; $display("FAIL umax_y%0d got %0d expected 325125", r, result[r*AW +: AW]);
      end
    end
    do_ack(0);
  endtask

  task automatic test_signed();
    int lat;
    logic [AW-1:0] exp_s;
    exp_s = AW'(-81280);
    run_op(1, mat_fill(8'h80), {5{8'h7F}}, 1'b0, lat);
    checks++;
    if (lat !== 26) begin
      failures++; $display("FAIL signed_latency got %0d expected 26", lat);
    end
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (s_result[r*AW +: AW] !== exp_s) begin
        failures++; $display("FAIL signed_y%0d got %h expected %h", r, s_result[r*AW +: AW], exp_s);
      end
    end
    do_ack(1);
  endtask

  task automatic test_accum();
    int lat;
    logic [AW-1:0] e;
    for (int pass = 0; pass < 3; pass++) begin
      run_op(0, mat_ident(), {5{8'd1}}, (pass == 1), lat);
      e = (pass == 1) ? AW'(2) : AW'(1);
      for (int r = 0; r < 5; r++) begin
        checks++;
        if (result[r*AW +: AW] !== e) begin
          failures++; $display("FAIL accum_p%0d_y%0d got %0d expected %0d", pass, r, result[r*AW +: AW], e);
        end
      end
      do_ack(0);
    end
  endtask

  task automatic test_handshake();
    int n;
    @(negedge clk);
    matrix = mat_ident(); vector = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}; accum = 0; start = 1;
    @(posedge clk); #1;
    // Keep start asserted with different operands through RUN and DONE.
    matrix = mat_fill(8'hFF); vector = {5{8'hFF}};
    n = 1;
    while (!valid && n < 100) begin @(posedge clk); n++; #1; end
    checks++;
    if (n !== 26) begin
      failures++; $display("FAIL hs_latency got %0d expected 26", n);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, valid} !== 2'b01 ||
          result !== {20'd5, 20'd4, 20'd3, 20'd2, 20'd1}) begin
        failures++; $display("FAIL hs_hold_c%0d got busy=%b valid=%b result=%h expected 0 1 held", i, busy, valid, result);
      end
    end
    @(negedge clk); ack = 1;
    @(posedge clk); #1;
    ack = 0;
    checks++;
    if ({busy, valid} !== 2'b00) begin
      failures++; $display("FAIL hs_ack_with_start got busy=%b valid=%b expected 0 0", busy, valid);
    end
    start = 0;
    @(posedge clk); #1;
    checks++;
    if ({busy, valid} !== 2'b00) begin
      failures++; $display("FAIL hs_idle got busy=%b valid=%b expected 0 0", busy, valid);
    end
    run_op(0, mat_rpc(), {5{8'd1}}, 1'b0, n);
    checks++;
    if (n !== 26 || result !== {20'd30, 20'd25, 20'd20, 20'd15, 20'd10}) begin
      failures++; $display("FAIL hs_restart got lat=%0d result=%h expected 26 and 30,25,20,15,10", n, result);
    end
    do_ack(0);
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(0, mat_fill(8'd3), {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, lat);
    checks++;
    if (result !== {5{20'd45}}) begin
      failures++; $display("FAIL b2b_first got %h expected 45 each", result);
    end
    do_ack(0);
    run_op(0, mat_rpc(), {5{8'd1}}, 1'b0, lat);
    checks++;
    if (lat !== 26 || result !== {20'd30, 20'd25, 20'd20, 20'd15, 20'd10}) begin
      failures++; $display("FAIL b2b_second got lat=%0d result=%h expected 26 and 30,25,20,15,10", lat, result);
    end
    do_ack(0);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    matrix = mat_ident(); vector = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}; accum = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || result[AW +: AW] !== AW'(2)) begin
      failures++; $display("FAIL midrun_pre got busy=%b y1=%0d expected 1 2", busy, result[AW +: AW]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, valid, result} !== '0) begin
      failures++; $display("FAIL midrun_reset got busy=%b valid=%b result=%h expected all 0", busy, valid, result);
    end
    @(negedge clk); rst_n = 1'b1;
    // Accumulating onto the reset-cleared results must give the plain product.
    run_op(0, mat_ident(), {5{8'd1}}, 1'b1, lat);
    checks++;
    if (lat !== 26 || result !== {5{20'd1}}) begin
      failures++; $display("FAIL midrun_after got lat=%0d result=%h expected 26 and 1 each", lat, result);
    end
    do_ack(0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_unsigned_max();
    test_signed();
    test_accum();
    test_handshake();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
